pipeline_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage 16-bit pipeline. It drives the enable and flush controls of the IF/ID, ID/EX and EX/MEM buffers and the PC. It also inserts MEM/WB bubbles. It handles three hazard classes: multi-cycle data-memory access with a ready handshake, load-use / R0 hazards, and taken branches resolved in EX.

---
 rtl/pipeline_stall_ctrl.sv | 164 ++++++++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage 16-bit pipeline.
// Freezes the pipe while a data-memory access is outstanding, inserts a
// one-cycle bubble on load-use / R0 hazards, and flushes IF/ID and ID/EX
// on a taken branch resolved in EX. A memory access that never completes
// within TIMEOUT wait cycles parks the controller in a sticky error state.
module pipeline_stall_ctrl #(
  parameter int TIMEOUT = 15,
  parameter int SCW     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           exmem_memRead,
  input  logic           exmem_memWrite,
  input  logic           mem_ready,
  input  logic           idex_memRead,
  input  logic           idex_r0Write,
  input  logic [3:0]     idex_RA1,
  input  logic [3:0]     ifid_RA1,
  input  logic [3:0]     ifid_RA2,
  input  logic           ifid_usesR0,
  input  logic           branch_taken,
  output logic           mem_req,
  output logic           pc_en,
  output logic           ifid_en,
  output logic           ifid_flush,
  output logic           idex_en,
  output logic           idex_flush,
  output logic           exmem_en,
  output logic           memwb_bubble,
  output logic           mem_timeout,
  output logic [SCW-1:0] stall_count
);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, ERROR} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t         state_reg, state_next;
  logic [7:0]     wait_cnt_reg, wait_cnt_next;
  logic           mem_timeout_reg, mem_timeout_next;
  logic [SCW-1:0] stall_count_reg;

  logic access;
  logic hazard;
  logic run;     // pipeline advances this cycle (branch/hazard/normal rules apply)
  logic freeze;  // whole pipe held, MEM/WB gets a bubble

  assign access = exmem_memRead | exmem_memWrite;
  assign hazard = (idex_memRead & ((idex_RA1 == ifid_RA1) | (idex_RA1 == ifid_RA2)))
                | (idex_r0Write & ifid_usesR0);

  // State, wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= 8'd0;
      mem_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      mem_timeout_reg <= mem_timeout_next;
    end
  end

  // Next-state logic and Mealy control outputs
  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    mem_timeout_next = mem_timeout_reg;
    run              = 1'b0;
    freeze           = 1'b0;
    mem_req          = 1'b0;
    pc_en            = 1'b0;
    ifid_en          = 1'b0;
    ifid_flush       = 1'b0;
    idex_en          = 1'b0;
    idex_flush       = 1'b0;
    exmem_en         = 1'b0;
    memwb_bubble     = 1'b0;

    case (state_reg)
      IDLE: begin
        mem_req = access;
        if (access && !mem_ready) begin
          freeze        = 1'b1;
          state_next    = MEM_WAIT;
          wait_cnt_next = 8'd1;
        end else begin
          run = 1'b1;
        end
      end
      MEM_WAIT: begin
        mem_req = access;
        if (mem_ready) begin
          // Release in the same cycle; a branch held in EX is acted on now.
          run           = 1'b1;
          state_next    = IDLE;
          wait_cnt_next = 8'd0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_reg == TIMEOUT_CNT) begin
            state_next       = ERROR;
            mem_timeout_next = 1'b1;
          end else begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
      end
      default: begin
        // ERROR: held until reset, mem_ready ignored
        freeze = 1'b1;
      end
    endcase

    if (run) begin
      if (branch_taken) begin
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else if (hazard) begin
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
      end
    end

    if (freeze) begin
      memwb_bubble = 1'b1;
    end

    // Everything quiet while reset is held
    if (!reset) begin
      mem_req      = 1'b0;
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      ifid_flush   = 1'b0;
      idex_en      = 1'b0;
      idex_flush   = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b0;
    end
  end

  // Saturating count of cycles in which the PC did not advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
    end else if (!pc_en && (stall_count_reg != {SCW{1'b1}})) begin
      stall_count_reg <= stall_count_reg + 1'b1;
    end
  end

  assign mem_timeout = mem_timeout_reg;
  assign stall_count = stall_count_reg;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl: memory freeze/release, hazard
// bubbles, branch flush priority, timeout error, reset behaviour and
// stall counter saturation.
module tb_pipeline_stall_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       exmem_memRead, exmem_memWrite, mem_ready;
  logic       idex_memRead, idex_r0Write;
  logic [3:0] idex_RA1, ifid_RA1, ifid_RA2;
  logic       ifid_usesR0, branch_taken;
  logic       mem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic       exmem_en, memwb_bubble, mem_timeout;
  logic [7:0] stall_count;
  logic [7:0] ctl;

  int tests_run = 0;
  int tests_failed = 0;

  // {mem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
  localparam logic [7:0] C_RESET    = 8'b0000_0000;
  localparam logic [7:0] C_NORM_ACC = 8'b1110_1010;
  localparam logic [7:0] C_NORM     = 8'b0110_1010;
  localparam logic [7:0] C_FREEZE   = 8'b1000_0001;
  localparam logic [7:0] C_HAZARD   = 8'b0000_1110;
  localparam logic [7:0] C_BRANCH   = 8'b0111_1110;
  localparam logic [7:0] C_ERROR    = 8'b0000_0001;

  always #5 clk = ~clk;

  assign ctl = {mem_req, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble};

  pipeline_stall_ctrl #(.TIMEOUT(15), .SCW(8)) dut (
    .clk(clk), .reset(reset),
    .exmem_memRead(exmem_memRead), .exmem_memWrite(exmem_memWrite),
    .mem_ready(mem_ready), .idex_memRead(idex_memRead), .idex_r0Write(idex_r0Write),
    .idex_RA1(idex_RA1), .ifid_RA1(ifid_RA1), .ifid_RA2(ifid_RA2),
    .ifid_usesR0(ifid_usesR0), .branch_taken(branch_taken),
    .mem_req(mem_req), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs are then changed/checked 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    exmem_memRead = 0; exmem_memWrite = 0; mem_ready = 0;
    idex_memRead = 0; idex_r0Write = 0; idex_RA1 = 4'd0;
    ifid_RA1 = 4'd1; ifid_RA2 = 4'd2; ifid_usesR0 = 0; branch_taken = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 0;

    // 1. reset with pending access, then release with zero-wait access
    exmem_memRead = 1; mem_ready = 0;
    #2;
    step();
    chk("rst_ctl", 32'(ctl), 32'(C_RESET));
    chk("rst_stall", 32'(stall_count), 32'd0);
    chk("rst_tmo", 32'(mem_timeout), 32'd0);
    reset = 1; mem_ready = 1;
    #1;
    chk("zw_ctl", 32'(ctl), 32'(C_NORM_ACC));
    step();
    chk("zw_stall", 32'(stall_count), 32'd0);

    // 2. load waits three cycles, releases on the fourth
    mem_ready = 0;
    #1;
    chk("ld_entry", 32'(ctl), 32'(C_FREEZE));
    step();
    chk("ld_wait1", 32'(ctl), 32'(C_FREEZE));
    step();
    chk("ld_wait2", 32'(ctl), 32'(C_FREEZE));
    step();
    mem_ready = 1;
    #1;
    chk("ld_release", 32'(ctl), 32'(C_NORM_ACC));
    step();
    chk("ld_stall", 32'(stall_count), 32'd3);
    exmem_memRead = 0; mem_ready = 0;
    #1;
    chk("ld_idle", 32'(ctl), 32'(C_NORM));

    // 3. load-use on RA2, then R0 hazard, then a non-matching load
    idex_memRead = 1; idex_RA1 = 4'd5; ifid_RA1 = 4'd3; ifid_RA2 = 4'd5;
    #1;
    chk("lu_bubble", 32'(ctl), 32'(C_HAZARD));
    step();
    idex_memRead = 0;
    #1;
    chk("lu_next", 32'(ctl), 32'(C_NORM));
    idex_r0Write = 1; ifid_usesR0 = 1;
    #1;
    chk("r0_bubble", 32'(ctl), 32'(C_HAZARD));
    step();
    idex_r0Write = 0; ifid_usesR0 = 0;
    idex_memRead = 1; idex_RA1 = 4'd5; ifid_RA1 = 4'd6; ifid_RA2 = 4'd7;
    #1;
    chk("lu_nomatch", 32'(ctl), 32'(C_NORM));
    step();
    chk("hz_stall", 32'(stall_count), 32'd5);

    // 4. branch beats load-use
    ifid_RA1 = 4'd5;
    branch_taken = 1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(C_BRANCH));
    step();
    chk("br_stall", 32'(stall_count), 32'd5);

    // 5. memory stall overrides branch, then times out
    idle_inputs();
    branch_taken = 1; exmem_memWrite = 1; mem_ready = 0;
    #1;
    chk("tmo_entry", 32'(ctl), 32'(C_FREEZE));
    step();
    for (int i = 1; i <= 15; i++) begin
      if (ctl !== C_FREEZE || mem_timeout !== 1'b0)
        chk($sformatf("tmo_wait%0d", i), 32'({ctl, mem_timeout}), 32'({C_FREEZE, 1'b0}));
      step();
    end
    chk("tmo_ctl", 32'(ctl), 32'(C_ERROR));
    chk("tmo_flag", 32'(mem_timeout), 32'd1);
    chk("tmo_stall", 32'(stall_count), 32'd21);
    mem_ready = 1;
    step();
    chk("tmo_sticky", 32'({ctl, mem_timeout}), 32'({C_ERROR, 1'b1}));
    chk("tmo_stall2", 32'(stall_count), 32'd22);
    reset = 0;
    #1;
    chk("tmo_rst_ctl", 32'(ctl), 32'(C_RESET));
    chk("tmo_rst_flag", 32'(mem_timeout), 32'd0);
    chk("tmo_rst_stall", 32'(stall_count), 32'd0);
    step();

    // 6. reset in the second MEM_WAIT cycle
    idle_inputs();
    reset = 1; exmem_memRead = 1; mem_ready = 0;
    step();
    step();
    chk("mr_wait2", 32'(ctl), 32'(C_FREEZE));
    reset = 0;
    #1;
    chk("mr_rst_ctl", 32'(ctl), 32'(C_RESET));
    chk("mr_rst_stall", 32'(stall_count), 32'd0);
    step();
    reset = 1; mem_ready = 1;
    #1;
    chk("mr_zw_ctl", 32'(ctl), 32'(C_NORM_ACC));
    step();
    chk("mr_zw_stall", 32'(stall_count), 32'd0);
    // A fresh stall must take the full wait path again (counter restarted)
    mem_ready = 0;
    step();
    step();
    mem_ready = 1;
    #1;
    chk("mr_release", 32'(ctl), 32'(C_NORM_ACC));
    step();
    chk("mr_stall2", 32'(stall_count), 32'd2);

    // Saturation: hold a hazard far beyond 255 stall cycles
    idle_inputs();
    idex_r0Write = 1; ifid_usesR0 = 1;
    for (int i = 0; i < 300; i++) step();
    chk("sat_stall", 32'(stall_count), 32'd255);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the bench always ends
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $finish;
  end

endmodule
